// File: rtl/rvc_compressor.sv
// rvc_compressor
//
// Streaming RV32C encoder. Each accepted 32-bit RV32I instruction is checked
// for an exact 16-bit RVC equivalent. Compressible instructions become 16-bit
// parcels, and all others stay 32 bits. The resulting half-words are packed
// little-endian into 32-bit words for the instruction-memory writer.
//
// Optional feature macro: RVC_COMPRESSOR_STATS_EN
//   When it is defined, n_cmp_o and n_words_o are saturating 16-bit counters.
//   When it is not defined, both outputs are tied to zero.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   in_instr_i   uncompressed instruction
//   in_valid_i   in_instr_i is valid
//   in_ready_o   input is accepted when in_valid_i && in_ready_o
//   flush_i      level request to emit any pending half-word
//   flush_done_o one-cycle pulse when a flush completes
//   out_word_o   packed word; the earlier parcel is in bits [15:0]
//   out_valid_o  out_word_o is valid
//   out_ready_i  downstream accepts the word
//   n_cmp_o      number of compressed instructions accepted
//   n_words_o    number of output handshakes

module rvc_compressor (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] in_instr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic [31:0] out_word_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] n_cmp_o,
    output logic [15:0] n_words_o
);

    typedef enum logic {EMPTY, HALF} pack_state_t;

    pack_state_t state;
    logic [15:0] pend;
    logic        flush_seen;

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        rd_c, rs1_c, rs2_c, imm_fits6;
    logic        is_addi, is_andi, is_slli, is_srli, is_srai;
    logic        is_lui, is_add, is_jalr, is_lw, is_sw, is_alu_c;
    logic [1:0]  alu_sel;
    logic        is_cmp;
    logic [15:0] parcel;
    logic        accept;
    logic        flush_go;

    assign opc   = in_instr_i[6:0];
    assign rd    = in_instr_i[11:7];
    assign f3    = in_instr_i[14:12];
    assign rs1   = in_instr_i[19:15];
    assign rs2   = in_instr_i[24:20];
    assign f7    = in_instr_i[31:25];
    assign imm_i = in_instr_i[31:20];
    assign imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

    // A register is a "primed" register (x8..x15) when its top two bits are 01.
    assign rd_c      = (rd[4:3]  == 2'b01);
    assign rs1_c     = (rs1[4:3] == 2'b01);
    assign rs2_c     = (rs2[4:3] == 2'b01);
    assign imm_fits6 = (imm_i[11:5] == {7{imm_i[5]}});

    assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_andi  = (opc == 7'b0010011) && (f3 == 3'b111);
    assign is_slli  = (opc == 7'b0010011) && (f3 == 3'b001) && (f7 == 7'b0000000);
    assign is_srli  = (opc == 7'b0010011) && (f3 == 3'b101) && (f7 == 7'b0000000);
    assign is_srai  = (opc == 7'b0010011) && (f3 == 3'b101) && (f7 == 7'b0100000);
    assign is_lui   = (opc == 7'b0110111);
    assign is_add   = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    assign is_jalr  = (opc == 7'b1100111) && (f3 == 3'b000) && (imm_i == 12'd0);
    assign is_lw    = (opc == 7'b0000011) && (f3 == 3'b010);
    assign is_sw    = (opc == 7'b0100011) && (f3 == 3'b010);
    assign is_alu_c = (opc == 7'b0110011) &&
                      (((f7 == 7'b0100000) && (f3 == 3'b000)) ||
                       ((f7 == 7'b0000000) && ((f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111))));
    assign alu_sel  = (f3 == 3'b000) ? 2'b00 :
                      (f3 == 3'b100) ? 2'b01 :
                      (f3 == 3'b110) ? 2'b10 : 2'b11;

    // Matcher. The first matching form wins. Each branch accepts only inputs
    // whose RVC expansion rebuilds the original instruction bit-for-bit.
    always_comb begin
        is_cmp = 1'b1;
        parcel = 16'h0000;
        if (is_addi && rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm_fits6)
            parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_addi && rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 &&
                 imm_i[3:0] == 4'd0 && imm_i[11:9] == {3{imm_i[9]}})
            parcel = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
        else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_fits6)
            parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_addi && rd_c && rs1 == 5'd2 && imm_i[1:0] == 2'b00 &&
                 imm_i[11:10] == 2'b00 && imm_i != 12'd0)
            parcel = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
        else if (is_lui && rd != 5'd0 && rd != 5'd2 &&
                 in_instr_i[31:17] == {15{in_instr_i[17]}} && in_instr_i[17:12] != 6'd0)
            parcel = {3'b011, in_instr_i[17], rd, in_instr_i[16:12], 2'b01};
        else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
            parcel = {4'b1000, rd, rs2, 2'b10};
        else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
            parcel = {4'b1001, rd, rs2, 2'b10};
        else if (is_jalr && rs1 != 5'd0 && rd == 5'd0)
            parcel = {4'b1000, rs1, 5'd0, 2'b10};
        else if (is_jalr && rs1 != 5'd0 && rd == 5'd1)
            parcel = {4'b1001, rs1, 5'd0, 2'b10};
        else if (in_instr_i == 32'h0010_0073)
            parcel = 16'h9002;
        else if (is_slli && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
            parcel = {4'b0000, rd, rs2, 2'b10};
        else if ((is_srli || is_srai) && rd == rs1 && rd_c && rs2 != 5'd0)
            parcel = {5'b10000, is_srai, rd[2:0], rs2, 2'b01};
        else if (is_andi && rd == rs1 && rd_c && imm_fits6)
            parcel = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
        else if (is_alu_c && rd == rs1 && rd_c && rs2_c)
            parcel = {6'b100011, rd[2:0], alu_sel, rs2[2:0], 2'b01};
        else if (is_lw && rd_c && rs1_c && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00)
            parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        else if (is_sw && rs2_c && rs1_c && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00)
            parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        else if (is_lw && rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00)
            parcel = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        else if (is_sw && rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00)
            parcel = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        else
            is_cmp = 1'b0;
    end

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // A flush is serviced once per request, only on a cycle where no input is
    // accepted and the output register is free.
    assign flush_go   = flush_i && !flush_seen && !accept && in_ready_o;

    // Packing FSM and output register. An output handshake clears the valid
    // flag. A word completed in the same cycle sets it again with the new
    // word, so back-to-back words flow without a bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= EMPTY;
            pend         <= 16'h0000;
            out_word_o   <= 32'h0000_0000;
            out_valid_o  <= 1'b0;
            flush_done_o <= 1'b0;
            flush_seen   <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;
            if (!flush_i)
                flush_seen <= 1'b0;
            if (accept) begin
                if (is_cmp) begin
                    if (state == EMPTY) begin
                        pend  <= parcel;
                        state <= HALF;
                    end else begin
                        out_word_o  <= {parcel, pend};
                        out_valid_o <= 1'b1;
                        state       <= EMPTY;
                    end
                end else begin
                    out_valid_o <= 1'b1;
                    if (state == EMPTY) begin
                        out_word_o <= in_instr_i;
                    end else begin
                        out_word_o <= {in_instr_i[15:0], pend};
                        pend       <= in_instr_i[31:16];
                    end
                end
            end else if (flush_go) begin
                flush_seen   <= 1'b1;
                flush_done_o <= 1'b1;
                if (state == HALF) begin
                    out_word_o  <= {16'h0001, pend};
                    out_valid_o <= 1'b1;
                    state       <= EMPTY;
                end
            end
        end
    end

`ifdef RVC_COMPRESSOR_STATS_EN
    logic [15:0] n_cmp_q;
    logic [15:0] n_words_q;

    // Saturating counters for compressed inputs and output handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_cmp_q   <= 16'h0000;
            n_words_q <= 16'h0000;
        end else begin
            if (accept && is_cmp && n_cmp_q != 16'hFFFF)
                n_cmp_q <= n_cmp_q + 16'd1;
            if (out_valid_o && out_ready_i && n_words_q != 16'hFFFF)
                n_words_q <= n_words_q + 16'd1;
        end
    end

    assign n_cmp_o   = n_cmp_q;
    assign n_words_o = n_words_q;
`else
    assign n_cmp_o   = 16'h0000;
    assign n_words_o = 16'h0000;
`endif

endmodule
